// File: rtl/game_flow_ctrl_pkg.sv
// Shared game definitions: state encoding and gameplay timing constants.
package game_flow_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DYING = 3'd2,
    ST_OVER  = 3'd3,
    ST_WIN   = 3'd4
  } game_state_t;

  localparam logic [1:0] LIVES_INIT     = 2'd3;
  localparam logic [8:0] TIME_INIT      = 9'd300;
  localparam logic [5:0] FRAMES_PER_SEC = 6'd60;
  localparam logic [6:0] DEATH_FRAMES   = 7'd120;
  localparam int         START_BIT      = 5;

endpackage

// File: rtl/game_flow_ctrl_level_timer.sv
// Level countdown: divides frame ticks into seconds and counts time_left down,
// flagging the tick that takes the last second to zero.
module level_timer
  import game_flow_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       enable,
  input  logic       frame_tick,
  output logic [8:0] time_left,
  output logic       expire
);

  logic [5:0] frame_cnt;
  logic       sec_done;

  assign sec_done = enable && frame_tick && (frame_cnt == FRAMES_PER_SEC - 6'd1);
  // Combinational so the controller leaves PLAY on the very tick that hits zero.
  assign expire   = sec_done && (time_left == 9'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      time_left <= '0;
    end else if (load) begin
      frame_cnt <= '0;
      time_left <= TIME_INIT;
    end else if (enable && frame_tick) begin
      if (sec_done) begin
        frame_cnt <= '0;
        if (time_left != 9'd0) begin
          time_left <= time_left - 9'd1;
        end
      end else begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game flow: start/play/death/game-over/win sequencing, lives
// bookkeeping and level restart pulses; every output is registered.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] movement,
  input  logic       frame_tick,
  input  logic       mario_dead,
  input  logic       flag_reached,
  input  logic       Win_end,
  input  logic       E_end,
  output logic       over,
  output logic       success,
  output logic       playing,
  output logic       freeze,
  output logic       level_rst,
  output logic [1:0] lives,
  output logic [8:0] time_left
);

  game_state_t state, next_state;
  logic        start_prev;
  logic        start_evt;
  logic [6:0]  death_cnt, death_cnt_nxt;
  logic [1:0]  lives_nxt;
  logic        level_rst_nxt;
  logic        timer_load;
  logic        timer_enable;
  logic        timer_expire;
  logic        death_done;
  logic        unused_movement;

  assign start_evt       = movement[START_BIT] && !start_prev;
  assign death_done      = frame_tick && (death_cnt == DEATH_FRAMES - 7'd1);
  assign unused_movement = ^(movement & ~(6'b1 << START_BIT));

  // A tick arriving with a death or flag event belongs to the new state, not the clock.
  assign timer_enable = (state == ST_PLAY) && !flag_reached && !mario_dead;

  level_timer u_level_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .enable     (timer_enable),
    .frame_tick (frame_tick),
    .time_left  (time_left),
    .expire     (timer_expire)
  );

  always_comb begin
    next_state    = state;
    lives_nxt     = lives;
    death_cnt_nxt = '0;
    timer_load    = 1'b0;
    level_rst_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_evt) begin
          next_state    = ST_PLAY;
          lives_nxt     = LIVES_INIT;
          timer_load    = 1'b1;
          level_rst_nxt = 1'b1;
        end
      end
      ST_PLAY: begin
        if (flag_reached) begin
          next_state = ST_WIN;
        end else if (mario_dead || timer_expire) begin
          next_state = ST_DYING;
        end
      end
      ST_DYING: begin
        if (death_done) begin
          if (lives <= 2'd1) begin
            lives_nxt  = 2'd0;
            next_state = ST_OVER;
          end else begin
            lives_nxt     = lives - 2'd1;
            timer_load    = 1'b1;
            level_rst_nxt = 1'b1;
            next_state    = ST_PLAY;
          end
        end else if (frame_tick) begin
          death_cnt_nxt = death_cnt + 7'd1;
        end else begin
          death_cnt_nxt = death_cnt;
        end
      end
      ST_OVER: begin
        if (start_evt && E_end) begin
          next_state = ST_IDLE;
        end
      end
      ST_WIN: begin
        if (start_evt && Win_end) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from next_state so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      start_prev <= 1'b0;
      death_cnt  <= '0;
      lives      <= '0;
      over       <= 1'b0;
      success    <= 1'b0;
      playing    <= 1'b0;
      freeze     <= 1'b0;
      level_rst  <= 1'b0;
    end else begin
      state      <= next_state;
      start_prev <= movement[START_BIT];
      death_cnt  <= death_cnt_nxt;
      lives      <= lives_nxt;
      over       <= (next_state == ST_OVER);
      success    <= (next_state == ST_WIN);
      playing    <= (next_state == ST_PLAY);
      freeze     <= (next_state == ST_DYING);
      level_rst  <= level_rst_nxt;
    end
  end

endmodule
